// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin writeback arbiter from NUM_FU functional units onto
// a CDB_PORTS-wide registered common data bus (PRF write, wakeup, ROB complete).
module cdb_arbiter #(
    parameter int NUM_FU        = 4,
    parameter int CDB_PORTS     = 2,
    parameter int PHYS_WIDTH    = 6,
    parameter int ROB_IDX_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_FU-1:0]        fu_valid,
    output logic [NUM_FU-1:0]        fu_ready,
    input  logic [PHYS_WIDTH-1:0]    fu_paddr   [NUM_FU],
    input  logic [31:0]              fu_data    [NUM_FU],
    input  logic [ROB_IDX_WIDTH-1:0] fu_rob_idx [NUM_FU],
    input  logic [NUM_FU-1:0]        fu_regf_we,
    output logic [CDB_PORTS-1:0]     cdb_valid,
    output logic [PHYS_WIDTH-1:0]    cdb_paddr   [CDB_PORTS],
    output logic [31:0]              cdb_data    [CDB_PORTS],
    output logic [ROB_IDX_WIDTH-1:0] cdb_rob_idx [CDB_PORTS],
    output logic [CDB_PORTS-1:0]     pregf_we
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CDB_PORTS-1:0]     cdb_valid_q, cdb_valid_d;
    logic [CDB_PORTS-1:0]     pregf_we_q, pregf_we_d;
    logic [PHYS_WIDTH-1:0]    cdb_paddr_q [CDB_PORTS];
    logic [PHYS_WIDTH-1:0]    cdb_paddr_d [CDB_PORTS];
    logic [31:0]              cdb_data_q [CDB_PORTS];
    logic [31:0]              cdb_data_d [CDB_PORTS];
    logic [ROB_IDX_WIDTH-1:0] cdb_rob_q [CDB_PORTS];
    logic [ROB_IDX_WIDTH-1:0] cdb_rob_d [CDB_PORTS];

    logic [NUM_FU-1:0]        grant;
    logic [CDB_PORTS-1:0]     port_vld;
    logic [PTR_W-1:0]         port_sel [CDB_PORTS];
    logic [PTR_W-1:0]         scan_idx;
    logic [PTR_W-1:0]         last_idx;
    logic                     any_grant;
    logic                     dup_paddr;
    int                       grant_cnt;

    // Scan from rr_ptr and hand the first CDB_PORTS valid FUs to ports 0,1,... in order
    always_comb begin
        grant     = '0;
        port_vld  = '0;
        any_grant = 1'b0;
        last_idx  = rr_ptr_q;
        scan_idx  = '0;
        grant_cnt = 0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            port_sel[p] = '0;
        end
        for (int s = 0; s < NUM_FU; s++) begin
            scan_idx = PTR_W'((int'(rr_ptr_q) + s) % NUM_FU);
            if (fu_valid[scan_idx] && (grant_cnt < CDB_PORTS)) begin
                grant[scan_idx] = 1'b1;
                last_idx        = scan_idx;
                any_grant       = 1'b1;
                for (int p = 0; p < CDB_PORTS; p++) begin
                    if (p == grant_cnt) begin
                        port_vld[p] = 1'b1;
                        port_sel[p] = scan_idx;
                    end
                end
                grant_cnt = grant_cnt + 1;
            end
        end
    end

    // Ready is exactly the grant, forced low while reset is held
    always_comb begin
        fu_ready = rst ? grant : '0;
    end

    // Next CDB contents: ungranted ports go invalid but keep their payload fields
    always_comb begin
        for (int p = 0; p < CDB_PORTS; p++) begin
            cdb_valid_d[p] = port_vld[p];
            pregf_we_d[p]  = port_vld[p] && fu_regf_we[port_sel[p]] &&
                             (fu_paddr[port_sel[p]] != '0);
            cdb_paddr_d[p] = port_vld[p] ? fu_paddr[port_sel[p]]   : cdb_paddr_q[p];
            cdb_data_d[p]  = port_vld[p] ? fu_data[port_sel[p]]    : cdb_data_q[p];
            cdb_rob_d[p]   = port_vld[p] ? fu_rob_idx[port_sel[p]] : cdb_rob_q[p];
        end
    end

    // Priority moves just past the last granted FU, and stays put when nothing is granted
    always_comb begin
        rr_ptr_d = any_grant ? PTR_W'((int'(last_idx) + 1) % NUM_FU) : rr_ptr_q;
    end

    // Two ports broadcasting the same nonzero tag in one cycle means rename broke
    always_comb begin
        dup_paddr = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            for (int q = p + 1; q < CDB_PORTS; q++) begin
                if (port_vld[p] && port_vld[q] &&
                    (fu_paddr[port_sel[p]] == fu_paddr[port_sel[q]]) &&
                    (fu_paddr[port_sel[p]] != '0)) begin
                    dup_paddr = 1'b1;
                end
            end
        end
    end

    a_unique_cdb_tag: assert property (@(posedge clk) disable iff (!rst) !dup_paddr);

    // CDB output registers and round-robin pointer; reset drops anything in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= '0;
            pregf_we_q  <= '0;
            for (int p = 0; p < CDB_PORTS; p++) begin
                cdb_paddr_q[p] <= '0;
                cdb_data_q[p]  <= '0;
                cdb_rob_q[p]   <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            pregf_we_q  <= pregf_we_d;
            for (int p = 0; p < CDB_PORTS; p++) begin
                cdb_paddr_q[p] <= cdb_paddr_d[p];
                cdb_data_q[p]  <= cdb_data_d[p];
                cdb_rob_q[p]   <= cdb_rob_d[p];
            end
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign pregf_we    = pregf_we_q;
    assign cdb_paddr   = cdb_paddr_q;
    assign cdb_data    = cdb_data_q;
    assign cdb_rob_idx = cdb_rob_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vectors with hand-computed expectations for cdb_arbiter
// (NUM_FU=4, CDB_PORTS=2).
module tb_cdb_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] fu_valid;
    logic [3:0] fu_ready;
    logic [5:0] fu_paddr   [4];
    logic [31:0] fu_data   [4];
    logic [4:0] fu_rob_idx [4];
    logic [3:0] fu_regf_we;
    logic [1:0] cdb_valid;
    logic [5:0] cdb_paddr   [2];
    logic [31:0] cdb_data   [2];
    logic [4:0] cdb_rob_idx [2];
    logic [1:0] pregf_we;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(
        .NUM_FU(4), .CDB_PORTS(2), .PHYS_WIDTH(6), .ROB_IDX_WIDTH(5)
    ) dut (
        .clk(clk), .rst(rst),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_paddr(fu_paddr), .fu_data(fu_data), .fu_rob_idx(fu_rob_idx),
        .fu_regf_we(fu_regf_we),
        .cdb_valid(cdb_valid), .cdb_paddr(cdb_paddr), .cdb_data(cdb_data),
        .cdb_rob_idx(cdb_rob_idx), .pregf_we(pregf_we)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one FU's result interface
    task automatic applyStimulus(input int i, input logic v, input logic [5:0] pa,
                                 input logic [31:0] d, input logic [4:0] rob, input logic we);
        fu_valid[i]   = v;
        fu_paddr[i]   = pa;
        fu_data[i]    = d;
        fu_rob_idx[i] = rob;
        fu_regf_we[i] = we;
    endtask

    task automatic clearAll();
        for (int i = 0; i < 4; i++) applyStimulus(i, 1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
    endtask

    // Advance to just after the next rising edge
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        clearAll();

        // Reset held with every FU valid: no readiness, CDB cleared
        for (int i = 0; i < 4; i++)
            applyStimulus(i, 1'b1, 6'(5 + i), 32'h100 + i, 5'(i + 1), 1'b1);
        nextCycle();
        nextCycle();
        checkOutput("rst_ready", fu_ready, 4'b0000);
        checkOutput("rst_valid", cdb_valid, 2'b00);
        checkOutput("rst_we", pregf_we, 2'b00);
        checkOutput("rst_paddr0", cdb_paddr[0], 6'd0);
        checkOutput("rst_data1", cdb_data[1], 32'd0);

        // Release reset: rr_ptr=0 grants FU0,FU1
        rst = 1'b1;
        #1;
        checkOutput("rel_ready", fu_ready, 4'b0011);

        // Full contention: pairs {5,6},{7,8},{5,6}; ready alternates with rr_ptr 2,0,2
        nextCycle();
        checkOutput("fc1_valid", cdb_valid, 2'b11);
        checkOutput("fc1_paddr0", cdb_paddr[0], 6'd5);
        checkOutput("fc1_paddr1", cdb_paddr[1], 6'd6);
        checkOutput("fc1_data0", cdb_data[0], 32'h100);
        checkOutput("fc1_we", pregf_we, 2'b11);
        checkOutput("fc1_ready", fu_ready, 4'b1100);
        nextCycle();
        checkOutput("fc2_paddr0", cdb_paddr[0], 6'd7);
        checkOutput("fc2_paddr1", cdb_paddr[1], 6'd8);
        checkOutput("fc2_rob1", cdb_rob_idx[1], 5'd4);
        checkOutput("fc2_ready", fu_ready, 4'b0011);
        nextCycle();
        checkOutput("fc3_paddr0", cdb_paddr[0], 6'd5);
        checkOutput("fc3_paddr1", cdb_paddr[1], 6'd6);

        // Single source FU3 (rr_ptr=2 here)
        clearAll();
        applyStimulus(3, 1'b1, 6'd12, 32'hDEADBEEF, 5'd9, 1'b1);
        #1;
        checkOutput("ss_ready", fu_ready, 4'b1000);
        nextCycle();
        checkOutput("ss_valid", cdb_valid, 2'b01);
        checkOutput("ss_paddr0", cdb_paddr[0], 6'd12);
        checkOutput("ss_data0", cdb_data[0], 32'hDEADBEEF);
        checkOutput("ss_rob0", cdb_rob_idx[0], 5'd9);
        checkOutput("ss_we", pregf_we, 2'b01);
        checkOutput("ss_hold_paddr1", cdb_paddr[1], 6'd6);

        // p0 / no-rd, with FU3 also valid to prove rr_ptr wrapped to 0
        clearAll();
        applyStimulus(1, 1'b1, 6'd0, 32'h11, 5'd1, 1'b1);
        applyStimulus(2, 1'b1, 6'd4, 32'h22, 5'd2, 1'b0);
        applyStimulus(3, 1'b1, 6'd9, 32'h33, 5'd3, 1'b1);
        #1;
        checkOutput("p0_ready", fu_ready, 4'b0110);
        nextCycle();
        checkOutput("p0_valid", cdb_valid, 2'b11);
        checkOutput("p0_we", pregf_we, 2'b00);
        checkOutput("p0_paddr0", cdb_paddr[0], 6'd0);
        checkOutput("p0_paddr1", cdb_paddr[1], 6'd4);
        checkOutput("p0_rob1", cdb_rob_idx[1], 5'd2);

        // All idle: nothing granted, fields hold, rr_ptr stays at 3
        clearAll();
        #1;
        checkOutput("idle_ready", fu_ready, 4'b0000);
        nextCycle();
        checkOutput("idle_valid", cdb_valid, 2'b00);
        checkOutput("idle_we", pregf_we, 2'b00);
        checkOutput("idle_hold_paddr1", cdb_paddr[1], 6'd4);
        applyStimulus(1, 1'b1, 6'd21, 32'h21, 5'd11, 1'b1);
        applyStimulus(2, 1'b1, 6'd22, 32'h22, 5'd12, 1'b1);
        applyStimulus(3, 1'b1, 6'd23, 32'h23, 5'd13, 1'b1);
        #1;
        checkOutput("rr3_ready", fu_ready, 4'b1010);
        nextCycle();
        checkOutput("rr3_paddr0", cdb_paddr[0], 6'd23);
        checkOutput("rr3_paddr1", cdb_paddr[1], 6'd21);

        // Steer rr_ptr to 0 (from 2) with FU3 alone
        clearAll();
        applyStimulus(3, 1'b1, 6'd30, 32'h30, 5'd14, 1'b1);
        nextCycle();
        checkOutput("steer_paddr0", cdb_paddr[0], 6'd30);

        // Backpressure: FU2 stalls, then wins port0 ahead of FU0
        clearAll();
        applyStimulus(0, 1'b1, 6'd40, 32'h40, 5'd20, 1'b1);
        applyStimulus(1, 1'b1, 6'd41, 32'h41, 5'd21, 1'b1);
        applyStimulus(2, 1'b1, 6'd42, 32'h42, 5'd22, 1'b1);
        #1;
        checkOutput("bp1_ready", fu_ready, 4'b0011);
        nextCycle();
        checkOutput("bp1_paddr0", cdb_paddr[0], 6'd40);
        checkOutput("bp1_paddr1", cdb_paddr[1], 6'd41);
        applyStimulus(0, 1'b1, 6'd43, 32'h43, 5'd23, 1'b1);
        applyStimulus(1, 1'b1, 6'd44, 32'h44, 5'd24, 1'b1);
        #1;
        checkOutput("bp2_ready", fu_ready, 4'b0101);
        nextCycle();
        checkOutput("bp2_paddr0", cdb_paddr[0], 6'd42);
        checkOutput("bp2_data0", cdb_data[0], 32'h42);
        checkOutput("bp2_paddr1", cdb_paddr[1], 6'd43);
        checkOutput("bp2_valid", cdb_valid, 2'b11);

        // Mid-operation asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mr_valid", cdb_valid, 2'b00);
        checkOutput("mr_we", pregf_we, 2'b00);
        checkOutput("mr_paddr0", cdb_paddr[0], 6'd0);
        checkOutput("mr_ready", fu_ready, 4'b0000);
        clearAll();
        applyStimulus(0, 1'b1, 6'd50, 32'h50, 5'd1, 1'b1);
        applyStimulus(2, 1'b1, 6'd52, 32'h52, 5'd2, 1'b1);
        applyStimulus(3, 1'b1, 6'd53, 32'h53, 5'd3, 1'b1);
        nextCycle();
        rst = 1'b1;
        #1;
        checkOutput("mr_rel_ready", fu_ready, 4'b0101);
        nextCycle();
        checkOutput("mr_rel_paddr0", cdb_paddr[0], 6'd50);
        checkOutput("mr_rel_paddr1", cdb_paddr[1], 6'd52);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Writeback arbiter between the functional units and the common data bus (CDB). It collects completed results from NUM_FU functional units over valid/ready handshakes and selects up to CDB_PORTS of them per cycle, using round-robin priority. It drives the registered CDB broadcast: physical register file write ports, reservation-station wakeup and ROB completion. The bus outputs connect directly to the PRF inputs rd_paddr, rd_data and pregf_we.

Parameters:
NUM_FU, 4, number of functional-unit result sources
CDB_PORTS, 2, number of CDB broadcast / PRF write ports (1 <= CDB_PORTS <= NUM_FU)
PHYS_WIDTH, 6, physical register index width
ROB_IDX_WIDTH, 5, ROB entry index width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
fu_valid[NUM_FU]  in  1  FU i presents a completed result
fu_ready[NUM_FU]  out  1  FU i result accepted this cycle
fu_paddr[NUM_FU]  in  PHYS_WIDTH  destination physical register
fu_data[NUM_FU]  in  32  result value
fu_rob_idx[NUM_FU]  in  ROB_IDX_WIDTH  ROB entry to mark complete
fu_regf_we[NUM_FU]  in  1  result writes a register (0 for stores and branches without rd)
cdb_valid[CDB_PORTS]  out  1  broadcast valid on port p
cdb_paddr[CDB_PORTS]  out  PHYS_WIDTH  broadcast tag, also PRF rd_paddr
cdb_data[CDB_PORTS]  out  32  broadcast value, also PRF rd_data
cdb_rob_idx[CDB_PORTS]  out  ROB_IDX_WIDTH  completing ROB entry
pregf_we[CDB_PORTS]  out  1  PRF write enable

Behaviour:
- Reset (rst=0, asynchronous):
  - cdb_valid, pregf_we, cdb_paddr, cdb_data and cdb_rob_idx clear to 0.
  - rr_ptr clears to 0.
  - fu_ready is 0 for as long as rst=0.
  - Results in flight are dropped. The ROB flush that accompanies reset owns recovery.
- State: rr_ptr (clog2(NUM_FU) bits) plus the CDB output registers. No result buffering: an ungranted FU holds its result and waits.
- Grant, combinational per cycle:
  - Scan FU indices rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - Grant the first min(CDB_PORTS, count of valid FUs) with fu_valid=1.
  - The k-th grant in scan order maps to CDB port k.
  - fu_ready[i]=1 iff FU i is granted. fu_ready may depend combinationally on fu_valid.
  - An FU must hold its payload stable while fu_valid=1 and fu_ready=0.
- Latency: exactly 1 cycle. A handshake (valid & ready) in cycle N appears on its CDB port in cycle N+1.
  - Port k without a grant in cycle N has cdb_valid=0 and pregf_we=0 in N+1.
  - Its data, paddr and rob_idx fields hold their previous value.
- pregf_we[p] = granted fu_regf_we && fu_paddr != 0, registered. Writes to p0 are suppressed.
  - cdb_valid[p] remains 1 in that case, so the ROB entry still completes.
- Round-robin update:
  - With at least one grant, rr_ptr <= (index of the last-granted FU + 1) mod NUM_FU. This wraps from NUM_FU-1 to 0.
  - With no grants, rr_ptr is unchanged.
- Fairness: a continuously valid FU is granted within ceil(NUM_FU/CDB_PORTS) cycles.
- Duplicate paddr on two ports in the same cycle is illegal (rename guarantees uniqueness). Behaviour is undefined; an assertion flags it.
- Each FU is granted at most once per cycle. Port indices never skip: if port k is valid, then all ports j < k are also valid.
- All-idle cycle: no grants, rr_ptr unchanged, all cdb_valid=0 in the next cycle.

Test Plan:
- Reset: hold rst=0 with all fu_valid=1. fu_ready=0 and cdb_valid=0. Release rst: the first grants are FU0→port0 and FU1→port1, visible on the CDB one cycle later.
- Full contention: all 4 FUs valid continuously with paddrs 5,6,7,8. CDB pairs repeat {5,6},{7,8},{5,6}; rr_ptr sequence is 0,2,0,2.
- Single source: only FU3 valid with paddr=12, data=0xDEADBEEF, rob=9. Next cycle port0 shows valid=1, paddr=12, data=0xDEADBEEF, rob=9, we=1. Port1 is invalid; rr_ptr becomes 0 (wrap).
- p0 / no-rd cases:
  - FU1 valid with paddr=0, regf_we=1 → cdb_valid=1, pregf_we=0.
  - FU2 valid with regf_we=0, paddr=4 → cdb_valid=1, pregf_we=0.
- Backpressure hold: FUs 0,1,2 valid and rr_ptr=0. FU2 stalls (ready=0) with its payload stable, then is granted on port0 next cycle, ahead of FU0, because rr_ptr=2.
- Mid-operation reset: assert rst=0 asynchronously between edges while the CDB is valid. cdb_valid and pregf_we drop immediately, without waiting for a clock edge. After release, rr_ptr restarts at 0.
